// File: rtl/ysyx_25030085_pkg.sv
// ysyx_25030085_pkg: shared widths, encodings and IFU state type
package ysyx_25030085_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK = 32'h0010_0073;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} ifu_state_t;
endpackage

// File: rtl/ysyx_25030085_ifu_pc.sv
// ysyx_25030085_ifu_pc: program counter with sequential/word-aligned redirect next-pc select
module ysyx_25030085_ifu_pc
  import ysyx_25030085_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);
  logic [XLEN-1:0] pc_n;
  assign pc_n = redirect_valid ? (redirect_pc & ~32'd3) : pc + 32'd4;
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else if (load) pc <= pc_n;
  end
endmodule

// File: rtl/ysyx_25030085_ifu.sv
// ysyx_25030085_ifu: single-outstanding fetch FSM; YSYX_25030085_IFU_EBREAK_HALT_EN stops fetch after ebreak
module ysyx_25030085_ifu
  import ysyx_25030085_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted
);
  ifu_state_t state, state_n;
  logic [XLEN-1:0] pc;
  logic hs, halt_hs;
  assign hs = state == HOLD && inst_ready;
`ifdef YSYX_25030085_IFU_EBREAK_HALT_EN
  assign halt_hs = hs && inst == EBREAK;
  assign halted = state == HALT;
`else
  assign halt_hs = 1'b0;
  assign halted = 1'b0;
`endif
  ysyx_25030085_ifu_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .load(hs && !halt_hs),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .pc(pc)
  );
  always_comb begin
    state_n = state == IDLE ? REQ :
              state == REQ  ? (imem_req_ready ? WAIT : REQ) :
              state == WAIT ? (imem_rsp_valid ? HOLD : WAIT) :
              state == HOLD ? (hs ? (halt_hs ? HALT : REQ) : HOLD) :
              HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inst <= NOP;
      inst_pc <= RESET_PC;
    end else begin
      state <= state_n;
      if (state == WAIT && imem_rsp_valid) begin
        inst <= imem_rsp_data;
        inst_pc <= pc;
      end
    end
  end
  assign imem_req_valid = state == REQ;
  assign imem_req_addr = pc;
  assign inst_valid = state == HOLD;
endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// tb_ysyx_25030085_ifu: directed self-checking bench for the fetch unit
module tb_ysyx_25030085_ifu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic halted;
  int n_cmp = 0;
  int n_bad = 0;
  int req_cnt = 0;

  ysyx_25030085_ifu dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && imem_req_valid && imem_req_ready) req_cnt <= req_cnt + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic go_hold(input logic [31:0] d);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = d;
    step();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic handshake();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl req_valid=%b inst_valid=%b halted=%b required 0 0 0", imem_req_valid, inst_valid, halted);
    end
    n_cmp++;
    if (inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0000 || imem_req_addr !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL reset_regs inst=%h inst_pc=%h addr=%h required 00000013 80000000 80000000", inst, inst_pc, imem_req_addr);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (imem_req_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_req req_valid=%b required 1", imem_req_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    inst_ready = 1'b1;
    n_cmp++;
    if (imem_req_addr !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL stream_addr0 addr=%h required 80000000", imem_req_addr);
    end
    for (int k = 0; k < 9; k++) begin
      imem_rsp_data = 32'h1000_0000 + 32'(k);
      step();
      exp_pc = 32'h8000_0000 + 32'(4 * (k / 3));
      n_cmp++;
      if (imem_req_valid !== (k % 3 == 2) || inst_valid !== (k % 3 == 1)) begin
        n_bad++;
        $display("FAIL stream_valid k=%0d req_valid=%b inst_valid=%b required %b %b", k, imem_req_valid, inst_valid, k % 3 == 2, k % 3 == 1);
      end
      if (k % 3 == 1) begin
        n_cmp++;
        if (inst !== 32'h1000_0000 + 32'(k) || inst_pc !== exp_pc) begin
          n_bad++;
          $display("FAIL stream_inst k=%0d inst=%h inst_pc=%h required %h %h", k, inst, inst_pc, 32'h1000_0000 + 32'(k), exp_pc);
        end
      end
      if (k % 3 == 2) begin
        n_cmp++;
        if (imem_req_addr !== exp_pc + 32'd4) begin
          n_bad++;
          $display("FAIL stream_addr k=%0d addr=%h required %h", k, imem_req_addr, exp_pc + 32'd4);
        end
      end
    end
    imem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
  endtask

  task automatic test_stall_redirect();
    int base;
    do_reset();
    base = req_cnt;
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
        n_bad++;
        $display("FAIL req_stall k=%0d req_valid=%b addr=%h required 1 80000000", k, imem_req_valid, imem_req_addr);
      end
      step();
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    step();
    n_cmp++;
    if (req_cnt - base !== 1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL req_single count=%0d req_valid=%b inst_valid=%b required 1 0 0", req_cnt - base, imem_req_valid, inst_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hAABB_CCDD;
    step();
    imem_rsp_data = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (inst !== 32'hAABB_CCDD || inst_pc !== 32'h8000_0000 || inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || req_cnt - base !== 1) begin
        n_bad++;
        $display("FAIL hold_stall k=%0d inst=%h inst_pc=%h inst_valid=%b req_valid=%b count=%0d required aabbccdd 80000000 1 0 1", k, inst, inst_pc, inst_valid, imem_req_valid, req_cnt - base);
      end
    end
    imem_rsp_valid = 1'b0;
    redirect_pc = 32'h8000_0103;
    handshake();
    redirect_pc = 32'h9000_0000;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      n_bad++;
      $display("FAIL redirect_addr req_valid=%b addr=%h required 1 80000100", imem_req_valid, imem_req_addr);
    end
    go_hold(32'h0000_0013);
    n_cmp++;
    if (inst_pc !== 32'h8000_0100) begin
      n_bad++;
      $display("FAIL redirect_inst_pc inst_pc=%h required 80000100", inst_pc);
    end
    redirect_valid = 1'b0;
    handshake();
    n_cmp++;
    if (imem_req_addr !== 32'h8000_0104) begin
      n_bad++;
      $display("FAIL redirect_ignored addr=%h required 80000104", imem_req_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    go_hold(32'h0000_0013);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    handshake();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_addr !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL wrap_align addr=%h required fffffffc", imem_req_addr);
    end
    go_hold(32'h0000_0013);
    handshake();
    n_cmp++;
    if (imem_req_addr !== 32'h0000_0000 || imem_req_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_addr addr=%h req_valid=%b required 00000000 1", imem_req_addr, imem_req_valid);
    end
  endtask

  task automatic test_ebreak();
    int base;
    do_reset();
    go_hold(32'h0000_0013);
    handshake();
    go_hold(32'h0010_0073);
    n_cmp++;
    if (inst !== 32'h0010_0073 || inst_pc !== 32'h8000_0004) begin
      n_bad++;
      $display("FAIL ebreak_fetch inst=%h inst_pc=%h required 00100073 80000004", inst, inst_pc);
    end
    base = req_cnt;
    handshake();
`ifdef YSYX_25030085_IFU_EBREAK_HALT_EN
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (halted !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL ebreak_halt k=%0d halted=%b req_valid=%b inst_valid=%b required 1 0 0", k, halted, imem_req_valid, inst_valid);
      end
      step();
    end
    n_cmp++;
    if (req_cnt !== base) begin
      n_bad++;
      $display("FAIL ebreak_no_req count=%0d required %0d", req_cnt, base);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
`else
    n_cmp++;
    if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008 || req_cnt !== base) begin
      n_bad++;
      $display("FAIL ebreak_plain halted=%b req_valid=%b addr=%h required 0 1 80000008", halted, imem_req_valid, imem_req_addr);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wait_idle req_valid=%b inst_valid=%b required 0 0", imem_req_valid, inst_valid);
    end
    step();
    n_cmp++;
    if (inst !== 32'h0000_0013 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL rst_late_rsp inst=%h req_valid=%b addr=%h required 00000013 1 80000000", inst, imem_req_valid, imem_req_addr);
    end
    step();
    n_cmp++;
    if (inst !== 32'h0000_0013 || inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_rsp_in_req inst=%h inst_valid=%b required 00000013 0", inst, inst_valid);
    end
    imem_rsp_valid = 1'b0;
    go_hold(32'h1234_5678);
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000_0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++;
    if (inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0000 || inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_over_hs inst=%h inst_pc=%h inst_valid=%b req_valid=%b required 00000013 80000000 0 0", inst, inst_pc, inst_valid, imem_req_valid);
    end
    step();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL rst_over_hs_pc req_valid=%b addr=%h required 1 80000000", imem_req_valid, imem_req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_redirect();
    test_wrap();
    test_ebreak();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_25030085_ifu.md
YSYX_25030085_IFU -- requirements
Module: ysyx_25030085_ifu

Interface
REQ-001 Parameter: RESET_PC, default 32'h8000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_req_addr  output  32  fetch address, equals pc.
REQ-007 imem_rsp_valid  input  1  response data valid.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 inst_valid  output  1  instruction available to decode stage.
REQ-010 inst_ready  input  1  decode stage consumes instruction.
REQ-011 inst  output  32  held instruction word.
REQ-012 inst_pc  output  32  address of inst.
REQ-013 redirect_valid  input  1  next PC differs from pc+4 (branch/jump); sampled only at inst handshake.
REQ-014 redirect_pc  input  32  target PC.
REQ-015 halted  output  1  fetch stopped after ebreak.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, HOLD, HALT.
REQ-017 IDLE -> REQ unconditionally next cycle; no outputs asserted in IDLE.
REQ-018 REQ: imem_req_valid=1, addr=pc held stable; on imem_req_ready -> WAIT.
REQ-019 WAIT: on imem_rsp_valid capture imem_rsp_data into inst and pc into inst_pc, -> HOLD.
REQ-020 Response arriving in same cycle as req_ready is not allowed; a memory response is accepted only in WAIT; rsp_valid in any other state ignored.
REQ-021 HOLD: inst_valid=1, inst/inst_pc stable until inst_valid & inst_ready.
REQ-022 At handshake: pc <= redirect_valid ? {redirect_pc[31:2],2'b00} : pc+32'd4; state -> REQ (same-cycle re-request next cycle; one instruction in flight maximum).
REQ-023 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Minimum fetch latency: request issued -> inst_valid 2 cycles after req_ready cycle when rsp_valid comes on first WAIT cycle.
REQ-025 redirect_valid outside the HOLD handshake cycle has no effect.
REQ-026 HALT: all request/valid outputs 0, halted=1, remains until rst.

Reset
REQ-027 rst high at a clock edge: state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), inst_pc=RESET_PC, halted=0, imem_req_valid=0, inst_valid=0.
REQ-028 rst mid-fetch (REQ/WAIT/HOLD) abandons the transaction; a late imem_rsp_valid after reset is ignored because state is IDLE/REQ.
REQ-029 rst overrides every simultaneous event including handshakes.

Configuration
REQ-030 Macro YSYX_25030085_IFU_EBREAK_HALT_EN.
REQ-031 Defined: at HOLD handshake with inst==32'h0010_0073, next state HALT instead of REQ, pc not updated.
REQ-032 Not defined: ebreak treated as ordinary instruction, halted tied 0, HALT state unreachable.

Structure
REQ-033 Shared package ysyx_25030085_pkg holds: IFU state enum, RESET_PC default, NOP encoding 32'h0000_0013, EBREAK encoding 32'h0010_0073, XLEN=32.
REQ-034 One sub-module ysyx_25030085_ifu_pc: PC register plus next-PC mux (pc+4 / aligned redirect), load-enable from handshake.

Verification
REQ-035 Reset then memory always ready, rsp next cycle, inst_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 issued; inst_valid every 3rd cycle.
REQ-036 Hold req_ready low 4 cycles -> req_valid and addr 0x80000000 stable all 4 cycles; single request counted.
REQ-037 inst_ready low 5 cycles in HOLD -> inst and inst_pc unchanged, no new imem request.
REQ-038 Handshake with redirect_valid=1, redirect_pc=0x80000103 -> next imem_req_addr=0x80000100.
REQ-039 With macro defined, fetch 0x00100073 at 0x80000004 -> halted=1 after handshake, no further requests; without macro, next request 0x80000008.
REQ-040 Assert rst during WAIT, then rsp_valid=1 data 0xDEADBEEF next cycle -> inst stays 0x00000013, first request after reset at 0x80000000.
